// File: rtl/register_bank.sv
// Parameterised register bank: one write port, one increment/decrement port,
// and three combinational read ports with wrap detection on the counter path.
module register_bank #(
    parameter int unsigned      WIDTH         = 8,
    parameter int unsigned      COUNT         = 4,
    parameter logic [WIDTH-1:0] DEFAULT_VALUE = '0,
    parameter int unsigned      SEL_W         = $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic [WIDTH-1:0] bus_in,
    input  logic             load_bus,
    input  logic [SEL_W-1:0] load_sel,

    input  logic             inc_n,
    input  logic             dec_n,
    input  logic [SEL_W-1:0] cnt_sel,

    input  logic             assert_bus,
    input  logic             assert_lhs,
    input  logic             assert_rhs,
    input  logic [SEL_W-1:0] bus_sel,
    input  logic [SEL_W-1:0] lhs_sel,
    input  logic [SEL_W-1:0] rhs_sel,

    output logic [WIDTH-1:0] bus_out,
    output logic [WIDTH-1:0] lhs_out,
    output logic [WIDTH-1:0] rhs_out,
    output logic             bus_en,
    output logic             lhs_en,
    output logic             rhs_en,

    output logic             wrap
);

    localparam logic [SEL_W:0]   COUNT_W  = (SEL_W + 1)'(COUNT);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] regs_q [COUNT];
    logic [WIDTH-1:0] regs_d [COUNT];
    logic             wrap_q;
    logic             wrap_d;

    logic             load_hit;
    logic             do_inc;
    logic             do_dec;
    logic             cnt_hit;

    function automatic logic in_range(input logic [SEL_W-1:0] sel);
        return {1'b0, sel} < COUNT_W;
    endfunction

    // Loop-based mux so a select beyond COUNT never indexes past the array.
    function automatic logic [WIDTH-1:0] read_port(input logic [WIDTH-1:0] regs [COUNT],
                                                   input logic [SEL_W-1:0] sel);
        logic [WIDTH-1:0] val;
        val = DEFAULT_VALUE;
        for (int i = 0; i < int'(COUNT); i++) begin
            if (sel == SEL_W'(i)) begin
                val = regs[i];
            end
        end
        return val;
    endfunction

    // Read ports drive data unconditionally; the external bus gates on *_en.
    assign bus_out = read_port(regs_q, bus_sel);
    assign lhs_out = read_port(regs_q, lhs_sel);
    assign rhs_out = read_port(regs_q, rhs_sel);

    assign bus_en  = ~assert_bus;
    assign lhs_en  = ~assert_lhs;
    assign rhs_en  = ~assert_rhs;

    assign wrap    = wrap_q;

    // A count colliding with a load on the same register is dropped entirely,
    // including its wrap pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
        load_hit = ~load_bus & in_range(load_sel);
        do_inc   = ~inc_n & dec_n;
        do_dec   = inc_n & ~dec_n;
        cnt_hit  = (do_inc | do_dec) & in_range(cnt_sel)
                   & ~(load_hit && (load_sel == cnt_sel));
        wrap_d   = 1'b0;

        for (int i = 0; i < int'(COUNT); i++) begin
            regs_d[i] = regs_q[i];
            if (cnt_hit && (cnt_sel == SEL_W'(i))) begin
                if (do_inc) begin
                    regs_d[i] = regs_q[i] + ONE;
                    wrap_d    = (regs_q[i] == ALL_ONES);
                end else begin
                    regs_d[i] = regs_q[i] - ONE;
                    wrap_d    = (regs_q[i] == '0);
                end
            end
            if (load_hit && (load_sel == SEL_W'(i))) begin
                regs_d[i] = bus_in;
            end
        end
    end

    // NOTE: this storage is flops, not a RAM macro, so every entry can be cleared by the async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(COUNT); i++) begin
                regs_q[i] <= DEFAULT_VALUE;
            end
            wrap_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            for (int i = 0; i < int'(COUNT); i++) begin
                regs_q[i] <= regs_d[i];
            end
            wrap_q <= wrap_d;
        end
    end

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: a default instance and a COUNT=3/DEFAULT=0xFF instance
// share stimulus; an array model is compared every cycle, plus literal spot checks.
module tb_register_bank;

    logic       clk;
    logic       rst_n;
    logic [7:0] bus_in;
    logic       load_bus;
    logic [1:0] load_sel;
    logic       inc_n;
    logic       dec_n;
    logic [1:0] cnt_sel;
    logic       assert_bus, assert_lhs, assert_rhs;
    logic [1:0] bus_sel, lhs_sel, rhs_sel;

    logic [7:0] a_bus_out, a_lhs_out, a_rhs_out;
    logic       a_bus_en, a_lhs_en, a_rhs_en, a_wrap;
    logic [7:0] b_bus_out, b_lhs_out, b_rhs_out;
    logic       b_bus_en, b_lhs_en, b_rhs_en, b_wrap;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Model state: index 0 is the default instance, index 1 the COUNT=3 instance.
    int mdl   [2][4];
    int mwrap [2];

    register_bank u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .bus_in(bus_in), .load_bus(load_bus), .load_sel(load_sel),
        .inc_n(inc_n), .dec_n(dec_n), .cnt_sel(cnt_sel),
        .assert_bus(assert_bus), .assert_lhs(assert_lhs), .assert_rhs(assert_rhs),
        .bus_sel(bus_sel), .lhs_sel(lhs_sel), .rhs_sel(rhs_sel),
        .bus_out(a_bus_out), .lhs_out(a_lhs_out), .rhs_out(a_rhs_out),
        .bus_en(a_bus_en), .lhs_en(a_lhs_en), .rhs_en(a_rhs_en),
        .wrap(a_wrap)
    );

    register_bank #(.WIDTH(8), .COUNT(3), .DEFAULT_VALUE(8'hFF)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .bus_in(bus_in), .load_bus(load_bus), .load_sel(load_sel),
        .inc_n(inc_n), .dec_n(dec_n), .cnt_sel(cnt_sel),
        .assert_bus(assert_bus), .assert_lhs(assert_lhs), .assert_rhs(assert_rhs),
        .bus_sel(bus_sel), .lhs_sel(lhs_sel), .rhs_sel(rhs_sel),
        .bus_out(b_bus_out), .lhs_out(b_lhs_out), .rhs_out(b_rhs_out),
        .bus_en(b_bus_en), .lhs_en(b_lhs_en), .rhs_en(b_rhs_en),
        .wrap(b_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int n_of(input int d);
        return (d == 0) ? 4 : 3;
    endfunction

    function automatic int dflt_of(input int d);
        return (d == 0) ? 0 : 255;
    endfunction

    function automatic int exp_read(input int d, input int sel);
        return (sel < n_of(d)) ? mdl[d][sel] : dflt_of(d);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 4; r++) mdl[d][r] = dflt_of(d);
            mwrap[d] = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a load lands if in range; a count moves the value by +/-1 modulo 256
    // unless both strobes are low, the index is out of range, or a load hits it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                int  ls, cs, delta, v;
                bit  do_load, do_cnt;
                ls      = int'(load_sel);
                cs      = int'(cnt_sel);
                do_load = !load_bus && (ls < n_of(d));
                delta   = (!inc_n && dec_n) ? 1 : ((inc_n && !dec_n) ? -1 : 0);
                do_cnt  = (delta != 0) && (cs < n_of(d)) && !(do_load && ls == cs);
                mwrap[d] = 0;
                if (do_cnt) begin
                    v = mdl[d][cs] + delta;
                    mwrap[d] = (v == 256 || v == -1) ? 1 : 0;
                    mdl[d][cs] = (v + 256) % 256;
                end
                if (do_load) mdl[d][ls] = int'(bus_in);
            end
        end
    end

    // Every-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("a_bus_out", int'(a_bus_out), exp_read(0, int'(bus_sel)));
            check("a_lhs_out", int'(a_lhs_out), exp_read(0, int'(lhs_sel)));
            check("a_rhs_out", int'(a_rhs_out), exp_read(0, int'(rhs_sel)));
            check("a_wrap",    int'(a_wrap),    mwrap[0]);
            check("b_bus_out", int'(b_bus_out), exp_read(1, int'(bus_sel)));
            check("b_lhs_out", int'(b_lhs_out), exp_read(1, int'(lhs_sel)));
            check("b_rhs_out", int'(b_rhs_out), exp_read(1, int'(rhs_sel)));
            check("b_wrap",    int'(b_wrap),    mwrap[1]);
            check("a_bus_en",  int'(a_bus_en),  assert_bus ? 0 : 1);
            check("a_lhs_en",  int'(a_lhs_en),  assert_lhs ? 0 : 1);
            check("b_rhs_en",  int'(b_rhs_en),  assert_rhs ? 0 : 1);
        end
    end

    task automatic idle();
        load_bus = 1'b1;
        inc_n    = 1'b1;
        dec_n    = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        assert_bus = 1'b1; assert_lhs = 1'b1; assert_rhs = 1'b1;
        bus_in = 8'h00; load_sel = 2'd0; cnt_sel = 2'd0;
        bus_sel = 2'd0; lhs_sel = 2'd3; rhs_sel = 2'd0;
        model_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        check("reset a_bus_out", int'(a_bus_out), 0);
        check("reset a_wrap",    int'(a_wrap),    0);
        check("reset b_lhs_oor", int'(b_lhs_out), 8'hFF);
        check("reset b_bus_out", int'(b_bus_out), 8'hFF);
        @(negedge clk);
        #2 rst_n = 1'b1;
        chk_en = 1'b1;

        // Load then read, visible only after the edge.
        step();
        load_bus = 1'b0; load_sel = 2'd2; bus_in = 8'h5A;
        bus_sel = 2'd2; lhs_sel = 2'd2; rhs_sel = 2'd1;
        #1 check("load pre-edge bus", int'(a_bus_out), 8'h00);
        step(); idle();
        check("load bus_out", int'(a_bus_out), 8'h5A);
        check("load lhs_out", int'(a_lhs_out), 8'h5A);
        check("load rhs_out", int'(a_rhs_out), 8'h00);

        // Increment wrap on reg1.
        load_bus = 1'b0; load_sel = 2'd1; bus_in = 8'hFF;
        step(); idle();
        inc_n = 1'b0; cnt_sel = 2'd1;
        step(); idle();
        check("inc wrap value", int'(a_rhs_out), 8'h00);
        check("inc wrap pulse", int'(a_wrap),    1);
        inc_n = 1'b0;
        step(); idle();
        check("inc after wrap value", int'(a_rhs_out), 8'h01);
        check("inc after wrap pulse", int'(a_wrap),    0);

        // Decrement wrap on reg3 (out of range for the COUNT=3 instance).
        bus_sel = 2'd3;
        dec_n = 1'b0; cnt_sel = 2'd3;
        step(); idle();
        check("dec wrap value",  int'(a_bus_out), 8'hFF);
        check("dec wrap pulse",  int'(a_wrap),    1);
        check("b dec oor wrap",  int'(b_wrap),    0);
        check("b dec oor value", int'(b_bus_out), 8'hFF);
        step();
        check("wrap one cycle", int'(a_wrap), 0);

        // Collisions around reg0.
        lhs_sel = 2'd0;
        load_bus = 1'b0; load_sel = 2'd0; bus_in = 8'h10;
        step(); idle();
        load_bus = 1'b0; load_sel = 2'd0; bus_in = 8'h20; inc_n = 1'b0; cnt_sel = 2'd0;
        step(); idle();
        check("same-reg load wins", int'(a_lhs_out), 8'h20);
        check("same-reg no wrap",   int'(a_wrap),    0);
        load_bus = 1'b0; load_sel = 2'd1; bus_in = 8'h33; inc_n = 1'b0; cnt_sel = 2'd0;
        step(); idle();
        check("split load reg1", int'(a_rhs_out), 8'h33);
        check("split inc reg0",  int'(a_lhs_out), 8'h21);
        inc_n = 1'b0; dec_n = 1'b0; cnt_sel = 2'd0;
        step(); idle();
        check("inc+dec no change", int'(a_lhs_out), 8'h21);
        check("inc+dec no wrap",   int'(a_wrap),    0);

        // Async reset between edges with a load pending, then a load while in reset.
        load_bus = 1'b0; load_sel = 2'd0; bus_in = 8'h99;
        #2 rst_n = 1'b0;
        #1;
        check("async rst bus_out", int'(a_bus_out), 0);
        check("async rst lhs_out", int'(a_lhs_out), 0);
        check("async rst rhs_out", int'(a_rhs_out), 0);
        check("async rst b_lhs",   int'(b_lhs_out), 8'hFF);
        bus_sel = 2'd2; load_sel = 2'd2; bus_in = 8'h77;
        step(); idle();
        check("load ignored in reset", int'(a_bus_out), 0);
        check("pending load dropped",  int'(a_lhs_out), 0);
        #2 rst_n = 1'b1;
        load_bus = 1'b0; load_sel = 2'd2; bus_in = 8'h44;
        step(); idle();
        check("first edge after reset a", int'(a_bus_out), 8'h44);
        check("first edge after reset b", int'(b_bus_out), 8'h44);

        // Enables and out-of-range handling on the COUNT=3 instance.
        assert_lhs = 1'b0;
        #1 check("lhs_en asserted", int'(b_lhs_en), 1);
        assert_lhs = 1'b1;
        #1 check("lhs_en released", int'(b_lhs_en), 0);
        lhs_sel = 2'd3;
        #1 check("b oor read", int'(b_lhs_out), 8'hFF);
        load_bus = 1'b0; load_sel = 2'd3; bus_in = 8'h12;
        rhs_sel = 2'd0; bus_sel = 2'd1;
        step(); idle();
        check("b oor load reg0", int'(b_rhs_out), 8'hFF);
        check("b oor load reg1", int'(b_bus_out), 8'hFF);
        check("a reg3 loaded",   int'(a_lhs_out), 8'h12);
        lhs_sel = 2'd2;
        #1 check("b oor load reg2", int'(b_lhs_out), 8'h44);

        step(); step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
